i2c_slave: RTL

- I2C target (responder) for 7-bit addressing, clocked by the system clock `clk_in`.
- Oversamples SCL/SDA, detects START/STOP, matches its address, ACKs writes and serves reads byte-by-byte through a simple parallel interface.
- Sits opposite the team's I2C master on the same bus.
- Open-drain on SDA only: no clock stretching, and SCL is an input.

---
 rtl/i2c_slave.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target with 7-bit addressing: oversampled SCL/SDA, START/STOP detection,
// ACKed writes and byte-wise reads through a parallel rx/tx interface.
module i2c_slave #(
   parameter logic [6:0] ADDRESS = 7'h50
) (
   input  logic       clk_in,
   input  logic       n_rst,
   input  logic       SCL,
   inout  wire        SDA,
   output logic [7:0] rx_data_out,
   output logic       rx_valid_out,
   input  logic [7:0] tx_data_in,
   output logic       tx_req_out,
   output logic       rd_wr_out,
   output logic       busy_out
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_HIT, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK
   } state_t;

   state_t     state, state_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [7:0] shift, shift_nx;
   logic [7:0] tx_buf, tx_buf_nx;
   logic       sda_oe, sda_oe_nx;
   logic [7:0] rx_data_nx;
   logic       rx_valid_nx, tx_req_nx, rd_wr_nx, busy_nx;

   logic scl_meta, scl_sync, scl_d;
   logic sda_meta, sda_sync, sda_d;
   logic scl_rise, scl_fall, start, stop;

   assign SDA = sda_oe ? 1'b0 : 1'bz;

   assign scl_rise = scl_sync & ~scl_d;
   assign scl_fall = ~scl_sync & scl_d;
   assign start    = scl_sync & scl_d & sda_d & ~sda_sync;
   assign stop     = scl_sync & scl_d & ~sda_d & sda_sync;

   always_ff @(posedge clk_in or negedge n_rst) begin
      if (!n_rst) begin
         scl_meta     <= 1'b1;
         scl_sync     <= 1'b1;
         scl_d        <= 1'b1;
         sda_meta     <= 1'b1;
         sda_sync     <= 1'b1;
         sda_d        <= 1'b1;
         state        <= IDLE;
         bit_cnt      <= 3'd0;
         shift        <= 8'h00;
         tx_buf       <= 8'h00;
         sda_oe       <= 1'b0;
         rx_data_out  <= 8'h00;
         rx_valid_out <= 1'b0;
         tx_req_out   <= 1'b0;
         rd_wr_out    <= 1'b0;
         busy_out     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         scl_meta     <= SCL;
         scl_sync     <= scl_meta;
         scl_d        <= scl_sync;
         sda_meta     <= SDA;
         sda_sync     <= sda_meta;
         sda_d        <= sda_sync;
         state        <= state_nx;
         bit_cnt      <= bit_cnt_nx;
         shift        <= shift_nx;
         tx_buf       <= tx_buf_nx;
         sda_oe       <= sda_oe_nx;
         rx_data_out  <= rx_data_nx;
         rx_valid_out <= rx_valid_nx;
         tx_req_out   <= tx_req_nx;
         rd_wr_out    <= rd_wr_nx;
         busy_out     <= busy_nx;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latches are inferred.
      state_nx    = state;
      bit_cnt_nx  = bit_cnt;
      shift_nx    = shift;
      tx_buf_nx   = tx_req_out ? tx_data_in : tx_buf;
      sda_oe_nx   = sda_oe;
      rx_data_nx  = rx_data_out;
      rx_valid_nx = 1'b0;
      tx_req_nx   = 1'b0;
      rd_wr_nx    = rd_wr_out;
      busy_nx     = busy_out;

      if (start) begin
         sda_oe_nx  = 1'b0;
         bit_cnt_nx = 3'd0;
         busy_nx    = 1'b0;
         state_nx   = ADDR;
      end else if (stop) begin
         sda_oe_nx = 1'b0;
         busy_nx   = 1'b0;
         state_nx  = IDLE;
      end else begin
         case (state)
            IDLE: ;
            ADDR: if (scl_rise) begin
               shift_nx   = {shift[6:0], sda_sync};
               bit_cnt_nx = bit_cnt + 3'd1;
               // shift[6:0] holds the seven address bits once the R/W bit arrives
               if (bit_cnt == 3'd7) begin
                  if (shift[6:0] == ADDRESS) begin
                     rd_wr_nx = sda_sync;
                     busy_nx  = 1'b1;
                     state_nx = ADDR_HIT;
                  end else begin
                     state_nx = IDLE;
                  end
               end
            end
            ADDR_HIT: if (scl_fall) begin
               sda_oe_nx = 1'b1;
               tx_req_nx = rd_wr_out;
               state_nx  = ADDR_ACK;
            end
            ADDR_ACK: if (scl_fall) begin
               bit_cnt_nx = 3'd0;
               if (rd_wr_out) begin
                  shift_nx  = tx_buf;
                  sda_oe_nx = ~tx_buf[7];
                  state_nx  = TX_BYTE;
               end else begin
                  sda_oe_nx = 1'b0;
                  state_nx  = RX_BYTE;
               end
            end
            RX_BYTE: if (scl_rise) begin
               shift_nx   = {shift[6:0], sda_sync};
               bit_cnt_nx = bit_cnt + 3'd1;
            end else if (scl_fall && bit_cnt == 3'd0) begin
               rx_data_nx  = shift;
               rx_valid_nx = 1'b1;
               sda_oe_nx   = 1'b1;
               state_nx    = RX_ACK;
            end
            RX_ACK: if (scl_fall) begin
               sda_oe_nx = 1'b0;
               state_nx  = RX_BYTE;
            end
            TX_BYTE: if (scl_rise) begin
               bit_cnt_nx = bit_cnt + 3'd1;
            end else if (scl_fall) begin
               // a fall with bit_cnt wrapped to 0 ends the byte
               if (bit_cnt == 3'd0) begin
                  sda_oe_nx = 1'b0;
                  tx_req_nx = 1'b1;
                  state_nx  = TX_ACK;
               end else begin
                  shift_nx  = {shift[6:0], 1'b0};
                  sda_oe_nx = ~shift[6];
               end
            end
            TX_ACK: if (scl_rise) begin
               if (sda_sync) begin
                  busy_nx  = 1'b0;
                  state_nx = IDLE;
               end
            end else if (scl_fall) begin
               shift_nx  = tx_buf;
               sda_oe_nx = ~tx_buf[7];
               state_nx  = TX_BYTE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
